// File: rtl/lzc_norm_shifter.sv
// Leading-zero count and left-normalize shifter for FP32 / dual-lane FP16
// mantissas. Two-stage valid/ready pipeline: stage 1 captures the beat and
// its leading-zero count, stage 2 holds the shifted mantissa and zero flags.

package lzc_norm_shifter_pkg;
    typedef enum logic [0:0] {
        FMT_FP32 = 1'b0,
        FMT_FP16 = 1'b1
    } fp_fmt_e;
endpackage

module lzc_norm_shifter
    import lzc_norm_shifter_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  fp_fmt_e     in_fmt,
    input  logic [25:0] in_X,
    input  logic        in_sticky_h,
    input  logic        in_sticky_l,
    output logic        out_valid,
    input  logic        out_ready,
    output fp_fmt_e     out_fmt,
    output logic [25:0] out_R,
    output logic [7:0]  out_lzc,
    output logic        out_zero_h,
    output logic        out_zero_l,
    output logic        out_sticky_h,
    output logic        out_sticky_l
);

    // Leading zeros of a 26-bit value; all-zero yields 26.
    function automatic logic [4:0] lzc26(input logic [25:0] x);
        logic [4:0] n;
        n = 5'd26;
        for (int i = 0; i < 26; i++) begin
            n = x[i] ? 5'(25 - i) : n;
        end
        return n;
    endfunction

    // Leading zeros of a 10-bit lane; all-zero yields 10.
    function automatic logic [3:0] lzc10(input logic [9:0] x);
        logic [3:0] n;
        n = 4'd10;
        for (int i = 0; i < 10; i++) begin
            n = x[i] ? 4'(9 - i) : n;
        end
        return n;
    endfunction

    logic        s1_valid_r;
    fp_fmt_e     s1_fmt_r;
    logic [25:0] s1_x_r;
    logic [7:0]  s1_lzc_r;
    logic        s1_sticky_h_r;
    logic        s1_sticky_l_r;

    logic        s2_adv_s;
    logic        s1_adv_s;
    logic [7:0]  in_lzc_s;
    logic [25:0] s2_r_s;
    logic [9:0]  s2_hi_s;
    logic [9:0]  s2_lo_s;
    logic        s2_zero_h_s;
    logic        s2_zero_l_s;

    // Output stage moves when empty or drained; input stage moves behind it.
    assign s2_adv_s = ~out_valid | out_ready;
    assign s1_adv_s = ~s1_valid_r | s2_adv_s;
    assign in_ready = s1_adv_s;

    // Count leading zeros of the incoming beat; FP16 gap bits never reach a lane count.
    always_comb begin
        in_lzc_s = 8'h00;
        case (in_fmt)
            FMT_FP32: in_lzc_s = {3'b000, lzc26(in_X)};
            FMT_FP16: in_lzc_s = {lzc10(in_X[25:16]), lzc10(in_X[9:0])};
            default:  in_lzc_s = 8'h00;
        endcase
    end

    // Shift each lane by its own count and derive zero flags; gap stays zero.
    always_comb begin
        s2_r_s      = 26'd0;
        s2_hi_s     = 10'd0;
        s2_lo_s     = 10'd0;
        s2_zero_h_s = 1'b0;
        s2_zero_l_s = 1'b0;
        case (s1_fmt_r)
            FMT_FP32: begin
                s2_r_s      = s1_x_r << s1_lzc_r[4:0];
                s2_zero_l_s = (s1_lzc_r[4:0] == 5'd26);
            end
            FMT_FP16: begin
                s2_hi_s     = s1_x_r[25:16] << s1_lzc_r[7:4];
                s2_lo_s     = s1_x_r[9:0] << s1_lzc_r[3:0];
                s2_r_s      = {s2_hi_s, 6'b000000, s2_lo_s};
                s2_zero_h_s = (s1_lzc_r[7:4] == 4'd10);
                s2_zero_l_s = (s1_lzc_r[3:0] == 4'd10);
            end
            default: begin
                s2_r_s      = 26'd0;
                s2_zero_h_s = 1'b0;
                s2_zero_l_s = 1'b0;
            end
        endcase
    end

    // Stage valid bits; reset discards any in-flight beats immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            if (s1_adv_s) begin
                s1_valid_r <= in_valid;
            end
            if (s2_adv_s) begin
                out_valid <= s1_valid_r;
            end
        end
    end

    // Stage 1 data capture on acceptance; data needs no reset.
    always_ff @(posedge clk) begin
        if (s1_adv_s && in_valid) begin
            s1_fmt_r      <= in_fmt;
            s1_x_r        <= in_X;
            s1_lzc_r      <= in_lzc_s;
            s1_sticky_h_r <= in_sticky_h;
            s1_sticky_l_r <= in_sticky_l;
        end
    end

    // Stage 2 data capture; holds steady while the consumer stalls.
    always_ff @(posedge clk) begin
        if (s2_adv_s && s1_valid_r) begin
            out_fmt      <= s1_fmt_r;
            out_R        <= s2_r_s;
            out_lzc      <= s1_lzc_r;
            out_zero_h   <= s2_zero_h_s;
            out_zero_l   <= s2_zero_l_s;
            out_sticky_h <= s1_sticky_h_r;
            out_sticky_l <= s1_sticky_l_r;
        end
    end

endmodule

// File: doc/lzc_norm_shifter.md
LZC_NORM_SHIFTER -- requirements
Module: lzc_norm_shifter

Interface
REQ-001 Parameters: none; lane geometry fixed (FP32: one 26-bit lane; FP16x2: hi lane [25:16], gap [15:10], lo lane [9:0]).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  upstream offers a beat.
REQ-005 in_ready  output  1  block accepts beat when in_valid & in_ready at rising edge.
REQ-006 in_fmt  input  fp_fmt_e  FP32 or FP16 (dual-lane).
REQ-007 in_X  input  26  unnormalized mantissa, lane-packed as above.
REQ-008 in_sticky_h, in_sticky_l  input  1 each  sticky bits; pass through unchanged.
REQ-009 out_valid  output  1  result beat valid.
REQ-010 out_ready  input  1  downstream accepts when out_valid & out_ready.
REQ-011 out_fmt  output  fp_fmt_e  format of the beat.
REQ-012 out_R  output  26  left-normalized mantissa, same lane packing.
REQ-013 out_lzc  output  8  FP32: [4:0] count, [7:5]=0; FP16: [7:4] hi count, [3:0] lo count.
REQ-014 out_zero_h, out_zero_l  output  1 each  lane all-zero flags (FP32 uses out_zero_l only; out_zero_h=0).
REQ-015 out_sticky_h, out_sticky_l  output  1 each  sticky pass-through.

Function
REQ-016 Block SHALL be a 2-stage pipeline: S1 registers accepted input plus leading-zero count; S2 registers shifted result and flags.
REQ-017 Latency SHALL be exactly 2 cycles from acceptance to out_valid when out_ready is held high; throughput one beat per cycle.
REQ-018 FP32: lzc = leading zeros of in_X[25:0], range 0..25; all-zero input -> lzc=26, out_R=0, out_zero_l=1.
REQ-019 FP16: per lane, lzc = leading zeros of 10-bit lane, range 0..9; all-zero lane -> lane lzc=10, lane output 0, lane zero flag=1.
REQ-020 out_R SHALL equal each lane shifted left by its lzc, zero-filled at LSB; bits shifted out above lane MSB impossible by construction.
REQ-021 FP16: input gap bits [15:10] SHALL be ignored (no effect on lzc/R); output gap bits SHALL be 0; lanes SHALL never exchange bits.
REQ-022 Stall rule: S2 advances when ~out_valid | out_ready; S1 advances when S1 empty or S2 advances; in_ready = ~S1_valid | S2_advance (combinational, no skid buffer).
REQ-023 While out_valid & ~out_ready, all out_* SHALL hold stable; no beat dropped, duplicated or reordered.
REQ-024 Simultaneous accept at input and output with both stages full SHALL shift pipeline by one with no bubble.
REQ-025 Data registers need not reset; valid bits SHALL.

Reset
REQ-026 On rst_n low (any time, including mid-stall): S1/S2 valid cleared immediately; out_valid=0; in_ready=1 while rst_n low is don't-care, SHALL be 1 the first cycle after deassertion.
REQ-027 In-flight beats at reset SHALL be discarded; outputs other than out_valid are don't-care while out_valid=0.

Verification
REQ-028 FP32 in_X=26'h0000400, out_ready=1 -> 2 cycles later out_R=26'h2000000, out_lzc=8'h0F, out_zero_l=0.
REQ-029 FP16 in_X=26'h0010080 (hi=10'h001, lo=10'h080) -> out_R=26'h2000200, out_lzc=8'h92, both zero flags 0.
REQ-030 FP32 in_X=0, in_sticky_l=1 -> out_R=0, out_lzc=8'h1A, out_zero_l=1, out_sticky_l=1.
REQ-031 FP16 in_X=26'h000FC00 (gap ones only) -> out_R=0, out_lzc=8'hAA, out_zero_h=out_zero_l=1.
REQ-032 Stream of 4 back-to-back beats, out_ready low cycles 2-4 -> in_ready drops after 2 beats buffered, all 4 delivered in order, outputs stable during stall.
REQ-033 Assert rst_n low with both stages full mid-stall -> out_valid=0 asynchronously; after release, first new beat appears exactly 2 cycles after acceptance.
